// File: rtl/preamble_frame_sequencer.sv
// Transmit-frame scheduler: preamble restart, preamble, sync word, payload, guard.
// Drives the preamble generator's reset/enable and one 4-bit valid/ready symbol stream.
module preamble_frame_sequencer #(
  parameter int          PRE_LEN   = 256,
  parameter logic [31:0] SYNC_WORD = 32'h1ACFFC1D,
  parameter int          GUARD_LEN = 16,
  parameter int          LEN_W     = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_frame_len,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pre_rst,
  output logic             o_pre_en,
  input  logic [3:0]       i_pre_sym,
  input  logic [3:0]       i_pl_data,
  input  logic             i_pl_valid,
  output logic             o_pl_ready,
  output logic [3:0]       o_out_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic             o_out_sof,
  output logic             o_out_eof,
  output logic             o_underrun
);

  localparam int LEN_MAX = (1 << LEN_W) - 1;
  localparam int MAX_A   = (PRE_LEN > LEN_MAX) ? PRE_LEN : LEN_MAX;
  localparam int MAX_B   = (GUARD_LEN > MAX_A) ? GUARD_LEN : MAX_A;
  localparam int MAX_C   = (MAX_B > 8) ? MAX_B : 8;
  localparam int CNT_W   = $clog2(MAX_C + 1);

  localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'(PRE_LEN - 1);
  localparam logic [CNT_W-1:0] SYNC_LAST  = CNT_W'(7);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD_LEN > 0) ? GUARD_LEN - 1 : 0);
  localparam bit               HAS_GUARD  = (GUARD_LEN > 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE_RST,
    S_PREAMBLE,
    S_SYNC,
    S_PAYLOAD,
    S_GUARD
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [LEN_W-1:0] r_len, w_len_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] w_len_ext;
  logic [3:0]       w_sync_nib;
  logic             w_last;

  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_len_ext = CNT_W'(r_len);

  // Sync word goes out MSB nibble first, indexed by the beat counter.
  always_comb begin
    w_sync_nib = SYNC_WORD[31:28];
    case (r_cnt[2:0])
      3'd0: w_sync_nib = SYNC_WORD[31:28];
      3'd1: w_sync_nib = SYNC_WORD[27:24];
      3'd2: w_sync_nib = SYNC_WORD[23:20];
      3'd3: w_sync_nib = SYNC_WORD[19:16];
      3'd4: w_sync_nib = SYNC_WORD[15:12];
      3'd5: w_sync_nib = SYNC_WORD[11:8];
      3'd6: w_sync_nib = SYNC_WORD[7:4];
      3'd7: w_sync_nib = SYNC_WORD[3:0];
      default: w_sync_nib = SYNC_WORD[31:28];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_len   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_len   <= w_len_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_len_nxt   = r_len;
    w_last      = 1'b0;
    o_busy      = (r_state != S_IDLE);
    o_pre_rst   = reset;
    o_pre_en    = 1'b0;
    o_pl_ready  = 1'b0;
    o_out_data  = 4'h0;
    o_out_valid = 1'b0;
    o_out_sof   = 1'b0;
    o_out_eof   = 1'b0;
    o_underrun  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_len_nxt   = i_frame_len;
          w_cnt_nxt   = '0;
          w_state_nxt = S_PRE_RST;
        end
      end

      S_PRE_RST: begin
        o_pre_rst   = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = S_PREAMBLE;
      end

      // Generator only advances on accepted beats so a stalled symbol holds.
      S_PREAMBLE: begin
        o_out_valid = 1'b1;
        o_out_data  = i_pre_sym;
        o_pre_en    = i_out_ready;
        o_out_sof   = (r_cnt == '0);
        if (i_out_ready) begin
          if (r_cnt == PRE_LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_SYNC;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end

      S_SYNC: begin
        o_out_valid = 1'b1;
        o_out_data  = w_sync_nib;
        w_last      = (r_cnt == SYNC_LAST);
        o_out_eof   = w_last && (r_len == '0) && !HAS_GUARD;
        if (i_out_ready) begin
          if (w_last) begin
            w_cnt_nxt = '0;
            if (r_len != '0)
              w_state_nxt = S_PAYLOAD;
            else if (HAS_GUARD)
              w_state_nxt = S_GUARD;
            else
              w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end

      // Zero-latency pass-through; an empty source stalls the frame, no filler.
      S_PAYLOAD: begin
        o_out_valid = i_pl_valid;
        o_out_data  = i_pl_data;
        o_pl_ready  = i_pl_valid & i_out_ready;
        o_underrun  = ~i_pl_valid & i_out_ready;
        w_last      = (w_cnt_inc == w_len_ext);
        o_out_eof   = w_last && !HAS_GUARD && i_pl_valid;
        if (i_pl_valid && i_out_ready) begin
          if (w_last) begin
            w_cnt_nxt   = '0;
            w_state_nxt = HAS_GUARD ? S_GUARD : S_IDLE;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end

      S_GUARD: begin
        o_out_valid = 1'b1;
        o_out_data  = 4'h0;
        w_last      = (r_cnt == GUARD_LAST);
        o_out_eof   = w_last;
        if (i_out_ready) begin
          if (w_last) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end

      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase

    o_done = o_out_eof & o_out_valid & i_out_ready;
  end

endmodule
